// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port 2048x32 data RAM.
// Port 0 is the CPU memory stage and port 1 is a secondary master. At most one
// access is granted per cycle. The RAM read is combinational, so read data is
// captured in the granted port's rdata register and returned one cycle later.
//
// Handshake: a master holds valid/we/addr/wdata stable until it sees ready high
// at a rising edge. ready is combinational and the transfer completes in the
// cycle where valid && ready. Every accepted request (read or write) produces
// exactly one rvalid pulse on the next cycle. For a write, rdata carries the
// pre-write content of the address.
//
// Configuration macro RAM_ARB_ROUND_ROBIN_EN:
//   defined   -> round-robin on contention (loser of the last grant wins).
//   undefined -> port 0 priority; port 1 is forced through after STARVE_LIMIT
//                consecutive denied cycles.
module ram_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Arbitration state: last winner (1 = port 1) and port 1 denial counter.
  logic       last_grant;
  logic [3:0] starve_cnt;

  logic              win0;
  logic              win1;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Grant decision; a lone requester always wins.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    win1 = m1_valid && (!m0_valid || !last_grant);
`else
    win1 = m1_valid && (!m0_valid || (starve_cnt == 4'(STARVE_LIMIT)));
`endif
    win0 = m0_valid && !win1;
  end

  // Handshake and RAM port; no grant is issued while reset is asserted.
  assign m0_ready  = win0 && !rst;
  assign m1_ready  = win1 && !rst;
  assign ram_we    = (m0_ready && m0_we) || (m1_ready && m1_we);
  assign ram_addr  = m1_ready ? m1_addr  : m0_addr;
  assign ram_wdata = m1_ready ? m1_wdata : m0_wdata;

  // Responses are masked during reset so a response launched in the cycle
  // before reset never becomes visible.
  assign m0_rvalid = rvalid0_q && !rst;
  assign m1_rvalid = rvalid1_q && !rst;
  assign m0_rdata  = rst ? '0 : rdata0_q;
  assign m1_rdata  = rst ? '0 : rdata1_q;

  // Response capture, grant history and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      last_grant <= 1'b1;
      starve_cnt <= 4'd0;
    end else begin
      rvalid0_q <= m0_ready;
      rvalid1_q <= m1_ready;
      if (m0_ready) rdata0_q <= ram_rdata;
      if (m1_ready) rdata1_q <= ram_rdata;
      if (m0_ready || m1_ready) last_grant <= m1_ready;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      starve_cnt <= 4'd0;
`else
      if (m1_valid && !m1_ready) starve_cnt <= starve_cnt + 4'd1;
      else                       starve_cnt <= 4'd0;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 2048x32
// RAM (combinational read, synchronous write). Inputs change on the falling
// edge; combinational outputs are sampled 1 ns later and registered outputs
// 1 ns after the rising edge.
module tb_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:2047] = '{default: '0};
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // behavioural RAM
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  // driver tasks
  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive0(1'b1, 1'b1, 11'h005, 32'h1111_1111);
    drive1(1'b1, 1'b1, 11'h006, 32'h2222_2222);
    #1;
    checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL reset_m0_ready got=%0h exp=0", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL reset_m1_ready got=%0h exp=0", m1_ready); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%0h exp=0", ram_we); end
    @(posedge clk); #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we2 got=%0h exp=0", ram_we); end
    @(negedge clk);
    rst = 1'b0; idle(); #1;
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m0_rvalid got=%0h exp=0", m0_rvalid); end
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m1_rvalid got=%0h exp=0", m1_rvalid); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL reset_m0_rdata got=%h exp=0", m0_rdata); end
    checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_m1_rdata got=%h exp=0", m1_rdata); end
    checks++; if (dut.last_grant !== 1'b1) begin failures++; $display("FAIL reset_last_grant got=%0h exp=1", dut.last_grant); end
    checks++; if (dut.starve_cnt !== 4'd0) begin failures++; $display("FAIL reset_starve_cnt got=%0h exp=0", dut.starve_cnt); end
    checks++; if (mem[5] !== 32'h0) begin failures++; $display("FAIL reset_no_write got=%h exp=0", mem[5]); end
  endtask

  task automatic test_single_read();
    do_reset();
    drive0(1'b1, 1'b0, 11'h005, '0); #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL single_m0_ready got=%0h exp=1", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL single_m1_ready got=%0h exp=0", m1_ready); end
    checks++; if (ram_addr !== 11'h005) begin failures++; $display("FAIL single_ram_addr got=%h exp=005", ram_addr); end
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL single_m0_rvalid got=%0h exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL single_m0_rdata got=%h exp=0", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL single_m1_rvalid got=%0h exp=0", m1_rvalid); end
    @(negedge clk); idle();
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL single_pulse_end got=%0h exp=0", m0_rvalid); end
  endtask

  task automatic test_write_then_read();
    do_reset();
    drive1(1'b1, 1'b1, 11'h7FF, 32'hDEAD_BEEF); #1;
    checks++; if (m1_ready !== 1'b1) begin failures++; $display("FAIL wr_m1_ready got=%0h exp=1", m1_ready); end
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL wr_ram_we got=%0h exp=1", ram_we); end
    @(posedge clk); #1;
    checks++; if (m1_rvalid !== 1'b1) begin failures++; $display("FAIL wr_m1_rvalid got=%0h exp=1", m1_rvalid); end
    checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL wr_m1_old_data got=%h exp=0", m1_rdata); end
    @(negedge clk);
    drive1(1'b0, 1'b0, '0, '0);
    drive0(1'b1, 1'b0, 11'h7FF, '0); #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL rd_m0_ready got=%0h exp=1", m0_ready); end
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL rd_m0_rvalid got=%0h exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_m0_rdata got=%h exp=deadbeef", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL rd_m1_rvalid got=%0h exp=0", m1_rvalid); end
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    do_reset();
    // Three writes then three reads on port 0, every cycle.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        drive0(1'b1, 1'b1, 11'(11'h040 + i), 32'h5000_0000 + 32'(i));
        exp_q.push_back(32'h0);
      end else begin
        drive0(1'b1, 1'b0, 11'(11'h040 + i - 3), '0);
        exp_q.push_back(32'h5000_0000 + 32'(i - 3));
      end
      @(posedge clk); #1;
      exp_d = exp_q.pop_front();
      checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_m0_rvalid[%0d] got=%0h exp=1", i, m0_rvalid); end
      checks++; if (m0_rdata !== exp_d) begin failures++; $display("FAIL b2b_m0_rdata[%0d] got=%h exp=%h", i, m0_rdata, exp_d); end
      @(negedge clk);
    end
    // Alternating lone requests: port 0, 1, 0, 1.
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin drive1(1'b0, 1'b0, '0, '0); drive0(1'b1, 1'b0, 11'(11'h040 + i), '0); end
      else            begin drive0(1'b0, 1'b0, '0, '0); drive1(1'b1, 1'b0, 11'(11'h040 + i), '0); end
      exp_d = (i == 3) ? 32'h0 : 32'h5000_0000 + 32'(i);
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== (i % 2 == 0)) begin failures++; $display("FAIL alt_m0_rvalid[%0d] got=%0h", i, m0_rvalid); end
      checks++; if (m1_rvalid !== (i % 2 == 1)) begin failures++; $display("FAIL alt_m1_rvalid[%0d] got=%0h", i, m1_rvalid); end
      checks++; if (((i % 2 == 0) ? m0_rdata : m1_rdata) !== exp_d) begin
        failures++; $display("FAIL alt_rdata[%0d] got=%h exp=%h", i, (i % 2 == 0) ? m0_rdata : m1_rdata, exp_d);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_contention();
    int k0 = 0;
    int k1 = 0;
    int sc = 0;
    int p1_wins = 0;
    logic exp_win;
    logic [DW-1:0] exp_d;
    do_reset();
    // Preload 0x100.. with A000_000j and 0x200.. with B000_000j via port 1.
    for (int j = 0; j < 16; j++) begin
      drive1(1'b1, 1'b1, (j < 8) ? 11'(11'h100 + j) : 11'(11'h200 + j - 8),
             (j < 8) ? 32'hA000_0000 + 32'(j) : 32'hB000_0000 + 32'(j - 8));
      @(negedge clk);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 1'b0, 11'(11'h100 + k0), '0);
      drive1(1'b1, 1'b0, 11'(11'h200 + k1), '0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_win = (i % 2 == 1);
`else
      exp_win = (i % 5 == 4);
      sc = exp_win ? 0 : sc + 1;
`endif
      #1;
      checks++; if (m0_ready !== !exp_win) begin failures++; $display("FAIL cont_m0_ready[%0d] got=%0h exp=%0h", i, m0_ready, !exp_win); end
      checks++; if (m1_ready !== exp_win) begin failures++; $display("FAIL cont_m1_ready[%0d] got=%0h exp=%0h", i, m1_ready, exp_win); end
      if (exp_win) begin exp_d = 32'hB000_0000 + 32'(k1); k1++; p1_wins++; end
      else         begin exp_d = 32'hA000_0000 + 32'(k0); k0++; end
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== !exp_win) begin failures++; $display("FAIL cont_m0_rvalid[%0d] got=%0h exp=%0h", i, m0_rvalid, !exp_win); end
      checks++; if (m1_rvalid !== exp_win) begin failures++; $display("FAIL cont_m1_rvalid[%0d] got=%0h exp=%0h", i, m1_rvalid, exp_win); end
      checks++; if ((exp_win ? m1_rdata : m0_rdata) !== exp_d) begin
        failures++; $display("FAIL cont_rdata[%0d] got=%h exp=%h", i, exp_win ? m1_rdata : m0_rdata, exp_d);
      end
      checks++; if (dut.starve_cnt !== 4'(sc)) begin failures++; $display("FAIL cont_starve_cnt[%0d] got=%0d exp=%0d", i, dut.starve_cnt, sc); end
      @(negedge clk);
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    checks++; if (p1_wins !== 5) begin failures++; $display("FAIL cont_p1_wins got=%0d exp=5", p1_wins); end
`else
    checks++; if (p1_wins !== 2) begin failures++; $display("FAIL cont_p1_wins got=%0d exp=2", p1_wins); end
`endif
    idle();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    drive0(1'b1, 1'b1, 11'h010, 32'h1234_5678);
    @(negedge clk);
    drive0(1'b1, 1'b0, 11'h010, '0); #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL midrst_accept got=%0h exp=1", m0_ready); end
    @(negedge clk);
    rst = 1'b1; idle(); #1;
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_m0_rvalid got=%0h exp=0", m0_rvalid); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL midrst_m0_rdata got=%h exp=0", m0_rdata); end
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_m0_rvalid2 got=%0h exp=0", m0_rvalid); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL midrst_m0_rdata2 got=%h exp=0", m0_rdata); end
    @(negedge clk);
    rst = 1'b0;
    drive0(1'b1, 1'b0, 11'h010, '0);
    drive1(1'b1, 1'b0, 11'h011, '0); #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL midrst_tie_m0 got=%0h exp=1", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL midrst_tie_m1 got=%0h exp=0", m1_ready); end
    @(posedge clk); #1;
    checks++; if (m0_rdata !== 32'h1234_5678) begin failures++; $display("FAIL midrst_read got=%h exp=12345678", m0_rdata); end
    @(negedge clk); idle();
  endtask

  task automatic test_write_read_tie();
    do_reset();
    drive0(1'b1, 1'b1, 11'h020, 32'hCAFE_F00D);
    drive1(1'b1, 1'b0, 11'h020, '0); #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL tie_m0_ready got=%0h exp=1", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL tie_m1_ready got=%0h exp=0", m1_ready); end
    @(posedge clk); #1;
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL tie_wr_old got=%h exp=0", m0_rdata); end
    @(negedge clk);
    drive0(1'b0, 1'b0, '0, '0); #1;
    checks++; if (m1_ready !== 1'b1) begin failures++; $display("FAIL tie_m1_ready2 got=%0h exp=1", m1_ready); end
    @(posedge clk); #1;
    checks++; if (m1_rvalid !== 1'b1) begin failures++; $display("FAIL tie_m1_rvalid got=%0h exp=1", m1_rvalid); end
    checks++; if (m1_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL tie_rd_new got=%h exp=cafef00d", m1_rdata); end
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL tie_m0_rvalid got=%0h exp=0", m0_rvalid); end
    @(negedge clk); idle();
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // test sequence and final report
  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_write_then_read();
    test_back_to_back();
    test_contention();
    test_reset_mid_op();
    test_write_read_tie();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 2048×32 data RAM between the CPU memory stage (port 0) and a secondary master such as a loader, debug or DMA engine (port 1). At most one access is granted per cycle. The grant drives the RAM's combinational-read/synchronous-write port directly. Read data is returned one cycle later on the granted port's response channel.

## Interface
- `ADDR_W`, 11, word address width; matches the RAM depth.
- `DATA_W`, 32, data width.
- `STARVE_LIMIT`, 4, maximum consecutive denied cycles for port 1 in fixed-priority mode; legal range 1..15.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `m0_valid`  in  1  port 0 request.
- `m0_ready`  out  1  port 0 request accepted this cycle.
- `m0_we`  in  1  port 0 write enable (1 = write, 0 = read).
- `m0_addr`  in  ADDR_W  port 0 word address.
- `m0_wdata`  in  DATA_W  port 0 write data.
- `m0_rvalid`  out  1  port 0 response pulse.
- `m0_rdata`  out  DATA_W  port 0 response data.
- `m1_*`  same set as port 0, for port 1.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM combinational read data.

## Operation
**Request rules**
- A requester holds `valid`, `we`, `addr` and `wdata` stable until it sees `ready` high at a rising edge.
- `mX_ready` is combinational. It is high only when `mX_valid` is high, that port wins, and `rst` is low.
- A request is accepted in the same cycle it is granted.

**RAM side**
- The winner's `addr`/`wdata` drive `ram_addr`/`ram_wdata`.
- `ram_we` = winner's `we`.
- With no winner: `ram_we` = 0 and `ram_addr`/`ram_wdata` follow port 0 inputs.

**Response**
- On acceptance, the `rdata` register of the granted port captures `ram_rdata`.
- Its `rvalid` pulses high for exactly one cycle.
- Responses are returned for writes as well. For a write, `rdata` is the pre-write content of the address.
- `mX_rdata` holds its value until the next response on that port.

**Arbitration**
- Selected by the configuration macro (see Configuration).
- A single requester always wins immediately in both modes.

**Storage**
- `last_grant` register (1 bit).
- `starve_cnt` register (4 bits).

## Timing
- Reset values:
  - `m0_rvalid` = `m1_rvalid` = 0.
  - `m0_rdata` = `m1_rdata` = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `starve_cnt` = 0.
  - While `rst` is high, both `ready` and `ram_we` are 0.
- Accept-to-response latency: 1 cycle. A request accepted in cycle N gives `rvalid` high in cycle N+1.
- Throughput: one access per cycle, back-to-back, including alternating ports.
- Simultaneous events:
  - A new acceptance in cycle N+1 on the same port gives `rvalid` high again in N+2 with no gap.
  - `rvalid` is never high on both ports in the same cycle.
- Reset mid-operation: a response pending for the cycle after `rst` is dropped. `rvalid` stays 0.
- Write visibility: write data lands at the rising edge ending the grant cycle. A read of the same address in the next cycle returns the new data.

## Configuration
- Macro: `RAM_ARB_ROUND_ROBIN_EN`.
- **Defined (round-robin):**
  - On contention, the port ≠ `last_grant` wins.
  - `last_grant` updates to the winner on every acceptance.
  - `starve_cnt` is unused and held at 0.
- **Undefined (fixed priority with anti-starvation):**
  - Port 0 wins on contention, except when `starve_cnt` == `STARVE_LIMIT`; then port 1 wins.
  - `starve_cnt` increments each cycle port 1 is valid and denied.
  - `starve_cnt` clears when port 1 is granted or `m1_valid` is low.
  - `last_grant` still tracks the winner but does not affect the decision.

## Test plan
- Reset, then a single read of addr 0x005 on port 0 only → `m0_ready` high in the same cycle; `m0_rvalid` = 1 next cycle with `m0_rdata` = 0x00000000; `m1_rvalid` stays 0.
- Port 1 writes 0xDEADBEEF to 0x7FF, then port 0 reads 0x7FF the following cycle:
  - write response: `m1_rdata` = 0 (old content);
  - read response: `m0_rdata` = 0xDEADBEEF.
- Both ports valid continuously with round-robin enabled → grants alternate 0,1,0,1 starting with port 0; each port gets one `rvalid` every 2 cycles.
- Both ports valid continuously with fixed priority and `STARVE_LIMIT` = 4 → port 0 wins 4 cycles, port 1 wins the 5th, pattern repeats; `starve_cnt` returns to 0 after each port 1 grant.
- `rst` asserted in the cycle after port 0 is accepted → `m0_rvalid` stays 0, `m0_rdata` = 0; after release, the first contended grant goes to port 0.
- Port 0 holds `valid` with `we` = 1 while port 1 reads the same address in a round-robin tie → the write and read occur in separate cycles per grant order; the read returns the written value if it is granted after the write.
